stack_controller: RTL and testbench

- Write-port arbiter and stack-pointer manager for the RPN calculator operand stack.
- Merges two write sources into a single registered write port for the stack RAM:
  - push path: operand values from the UART number parser;
  - answer path: results from the ALU.
- Tracks stack occupancy.
- Flags illegal requests: overflow, underflow, simultaneous requests.

---
 rtl/stack_controller.sv | 91 +++++++++
 tb/tb_stack_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stack_controller.sv
// stack_controller: write-port arbiter and stack-pointer manager for the
// RPN calculator operand stack. Merges the push path (UART parser) and the
// answer path (ALU) into one registered RAM write port, tracks occupancy and
// flags rejected requests with a one-cycle err pulse.
module stack_controller #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] push_din,
  input  logic                  push_en,
  input  logic [DATA_WIDTH-1:0] ans_din,
  input  logic                  ans_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] TWO_CNT   = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] dout_nxt;
  logic                  wen_nxt;
  logic [ADDR_WIDTH-1:0] waddr_nxt;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  err_nxt;

  // Arbitrate the two sources and compute the next write-port/pointer values.
  always_comb begin
    dout_nxt  = dout;
    wen_nxt   = 1'b0;
    waddr_nxt = waddr;
    count_nxt = count;
    err_nxt   = 1'b0;
    if (push_en && ans_en) begin
      // Simultaneous requests: neither source wins.
      err_nxt = 1'b1;
    end else if (push_en) begin
      if (count != DEPTH_CNT) begin
        dout_nxt  = push_din;
        waddr_nxt = count[ADDR_WIDTH-1:0];
        wen_nxt   = 1'b1;
        count_nxt = count + ONE_CNT;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (ans_en) begin
      if (count >= TWO_CNT) begin
        // Result overwrites the second-from-top slot; old top is dropped.
        dout_nxt  = ans_din;
        waddr_nxt = ADDR_WIDTH'(count - TWO_CNT);
        wen_nxt   = 1'b1;
        count_nxt = count - ONE_CNT;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // Output and pointer registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      wen   <= 1'b0;
      waddr <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      dout  <= dout_nxt;
      wen   <= wen_nxt;
      waddr <= waddr_nxt;
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  // Occupancy flags decoded straight from the registered count.
  always_comb begin
    full  = (count == DEPTH_CNT);
    empty = (count == '0);
  end

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: directed scenarios followed by
// randomized traffic, compared against a queue-based model of the stack.
module tb_stack_controller;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] push_din;
  logic          push_en;
  logic [DW-1:0] ans_din;
  logic          ans_en;
  logic [DW-1:0] dout;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          err;

  stack_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_din(push_din), .push_en(push_en),
    .ans_din(ans_din), .ans_en(ans_en),
    .dout(dout), .wen(wen), .waddr(waddr), .count(count),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the stack itself plus the expected write-port state.
  logic [DW-1:0] mq[$];
  int            exp_dout, exp_wen, exp_waddr, exp_err;
  logic [DW-1:0] ram_mirror [DEPTH];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},  int'(dout),  exp_dout);
    check({tag, ".wen"},   int'(wen),   exp_wen);
    check({tag, ".waddr"}, int'(waddr), exp_waddr);
    check({tag, ".count"}, int'(count), mq.size());
    check({tag, ".full"},  int'(full),  int'(mq.size() == DEPTH));
    check({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
    check({tag, ".err"},   int'(err),   exp_err);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_dout = 0; exp_wen = 0; exp_waddr = 0; exp_err = 0;
  endtask

  // Apply one cycle of stimulus, advance the model, check after the edge.
  task automatic step(input string tag, input bit p, input logic [DW-1:0] pd,
                      input bit a, input logic [DW-1:0] ad);
    logic [DW-1:0] t;
    push_en = p; push_din = pd; ans_en = a; ans_din = ad;
    @(posedge clk); #1;
    exp_wen = 0; exp_err = 0;
    if (p && a) exp_err = 1;
    else if (p) begin
      if (mq.size() < DEPTH) begin
        exp_waddr = mq.size(); exp_dout = int'(pd); exp_wen = 1;
        mq.push_back(pd);
      end else exp_err = 1;
    end else if (a) begin
      if (mq.size() >= 2) begin
        exp_waddr = mq.size() - 2; exp_dout = int'(ad); exp_wen = 1;
        t = mq.pop_back(); t = mq.pop_back();
        mq.push_back(ad);
      end else exp_err = 1;
    end
    if (wen) ram_mirror[waddr] = dout;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; #2;
    model_reset();
    check_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push_en = 0; ans_en = 0; push_din = 10; ans_din = 20;
    model_reset();
    repeat (2) @(posedge clk);
    #1; check_all("por");
    rst = 1'b0;

    // Reset then standby, then a single push and standby hold.
    step("standby", 0, 16'd10, 0, 16'd20);
    step("push1",   1, 16'd10, 0, 16'd0);
    step("hold",    0, 16'd0,  0, 16'd0);

    // Answer: push 10, 30, answer 20, then underflow.
    do_reset();
    step("pa", 1, 16'd10, 0, 16'd0);
    step("pb", 1, 16'd30, 0, 16'd0);
    step("ans", 0, 16'd0, 1, 16'd20);
    step("ans_uflow", 0, 16'd0, 1, 16'd21);

    // Fill to DEPTH, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("fill", 1, DW'(i), 0, 16'd0);
    step("oflow", 1, 16'd99, 0, 16'd0);

    // Conflict with three entries.
    do_reset();
    for (int i = 0; i < 3; i++) step("c_fill", 1, DW'(100 + i), 0, 16'd0);
    step("conflict", 1, 16'd7, 1, 16'd8);

    // Asynchronous reset between edges with push_en held.
    do_reset();
    for (int i = 0; i < 5; i++) step("r_fill", 1, DW'(200 + i), 0, 16'd0);
    push_en = 1; push_din = 16'd55;
    #2; rst = 1'b1; #1;
    model_reset();
    check_all("async_rst");
    #1; rst = 1'b0;

    // Randomized traffic with a slowly alternating push/answer bias.
    for (int c = 0; c < 3000; c++) begin
      int r;
      int bias;
      bit p, a;
      bias = ((c / 60) % 2 == 0) ? 65 : 25;
      r = int'($urandom_range(0, 99));
      p = (r < bias);
      a = (int'($urandom_range(0, 99)) < (90 - bias));
      if (($urandom_range(0, 3)) != 0 && p && a) a = 1'b0;
      step("rand", p, DW'($urandom), a, DW'($urandom));
    end
    // Written RAM image must match the model stack contents.
    for (int i = 0; i < mq.size(); i++)
      check("ram_image", int'(ram_mirror[i]), int'(mq[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
